// File: rtl/decode_in_stim_driver.sv
// decode_in_stim_driver: FIFO-buffered stimulus driver for the decode stage input bus
module decode_in_stim_driver #(
   parameter int                 INSTR_W   = 16,
   parameter int                 NPC_W     = 16,
   parameter int                 DEPTH     = 4,
   parameter int                 AUTO_NPC  = 0,
   parameter logic [NPC_W-1:0]   NPC_RESET = 16'h3000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [INSTR_W-1:0]         push_instr,
   input  logic [NPC_W-1:0]           push_npc,
   input  logic                       flush,
   input  logic                       enable_decode,
   output logic [INSTR_W-1:0]         Instr_dout,
   output logic [NPC_W-1:0]           npc_in,
   output logic                       out_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic [15:0]                underrun_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [INSTR_W-1:0] mem_instr [DEPTH];
   logic [NPC_W-1:0]   mem_npc [DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [NPC_W-1:0]   npc_cnt;
   logic               push, pop, under;
   assign push_ready = reset && (count != CW'(DEPTH));
   assign push       = push_valid && push_ready && !flush;
   assign pop        = enable_decode && (count != '0) && !flush;
   assign under      = enable_decode && (count == '0) && !flush;
   always_ff @(posedge clock)
      if (push) begin
         mem_instr[wr_ptr] <= push_instr;
         mem_npc[wr_ptr]   <= push_npc;
      end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         Instr_dout   <= NOP_INSTR;
         npc_in       <= NPC_RESET;
         out_valid    <= 1'b0;
         count        <= '0;
         underrun_cnt <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         npc_cnt      <= NPC_RESET;
      end else if (flush) begin
         Instr_dout <= NOP_INSTR;
         out_valid  <= 1'b0;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         npc_cnt    <= NPC_RESET;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            Instr_dout <= mem_instr[rd_ptr];
            npc_in     <= (AUTO_NPC != 0) ? npc_cnt : mem_npc[rd_ptr];
            out_valid  <= 1'b1;
            npc_cnt    <= npc_cnt + 1'b1;
         end
         if (under) begin
            Instr_dout <= NOP_INSTR;
            out_valid  <= 1'b0;
            if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: tb/tb_decode_in_stim_driver.sv
// tb_decode_in_stim_driver: queue-model checker plus directed vectors for the decode input driver
module tb_decode_in_stim_driver;
   logic        clock = 1'b0, reset = 1'b0, push_valid = 1'b0, flush = 1'b0, enable_decode = 1'b0;
   logic [15:0] push_instr = '0, push_npc = '0;
   logic        push_ready, out_valid, push_ready_a, out_valid_a, push_ready_w, out_valid_w;
   logic [15:0] Instr_dout, npc_in, underrun_cnt, instr_a, npc_a, under_a, instr_w, npc_w, under_w;
   logic [2:0]  count, count_a, count_w;
   int          n_cmp = 0, n_bad = 0;
   bit          chk_on = 1'b0;

   decode_in_stim_driver dut (
      .clock(clock), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
      .push_instr(push_instr), .push_npc(push_npc), .flush(flush), .enable_decode(enable_decode),
      .Instr_dout(Instr_dout), .npc_in(npc_in), .out_valid(out_valid), .count(count),
      .underrun_cnt(underrun_cnt));
   decode_in_stim_driver #(.AUTO_NPC(1)) dut_a (
      .clock(clock), .reset(reset), .push_valid(push_valid), .push_ready(push_ready_a),
      .push_instr(push_instr), .push_npc(push_npc), .flush(flush), .enable_decode(enable_decode),
      .Instr_dout(instr_a), .npc_in(npc_a), .out_valid(out_valid_a), .count(count_a),
      .underrun_cnt(under_a));
   decode_in_stim_driver #(.AUTO_NPC(1), .NPC_RESET(16'hFFFF)) dut_w (
      .clock(clock), .reset(reset), .push_valid(push_valid), .push_ready(push_ready_w),
      .push_instr(push_instr), .push_npc(push_npc), .flush(flush), .enable_decode(enable_decode),
      .Instr_dout(instr_w), .npc_in(npc_w), .out_valid(out_valid_w), .count(count_w),
      .underrun_cnt(under_w));

   always #5 clock = ~clock;

   typedef struct {logic [15:0] instr; logic [15:0] npc;} ent_t;
   ent_t        q[$];
   ent_t        m_e;
   bit          m_rdy;
   logic [15:0] m_instr = '0, m_npc = 16'h3000, m_npc_a = 16'h3000, m_npc_w = 16'hFFFF;
   logic [15:0] cnt_a = 16'h3000, cnt_w = 16'hFFFF;
   int          m_valid = 0, m_under = 0;

   always @(posedge clock or negedge reset)
      if (!reset) begin
         q.delete();
         m_instr = '0; m_npc = 16'h3000; m_npc_a = 16'h3000; m_npc_w = 16'hFFFF;
         cnt_a = 16'h3000; cnt_w = 16'hFFFF; m_valid = 0; m_under = 0;
      end else if (flush) begin
         q.delete();
         m_instr = '0; m_valid = 0; cnt_a = 16'h3000; cnt_w = 16'hFFFF;
      end else begin
         m_rdy = q.size() < 4;
         if (enable_decode) begin
            if (q.size() > 0) begin
               m_e = q.pop_front();
               m_instr = m_e.instr; m_npc = m_e.npc; m_npc_a = cnt_a; m_npc_w = cnt_w;
               cnt_a = cnt_a + 16'd1; cnt_w = cnt_w + 16'd1; m_valid = 1;
            end else begin
               m_instr = '0; m_valid = 0;
               if (m_under < 65535) m_under++;
            end
         end
         if (push_valid && m_rdy) q.push_back('{push_instr, push_npc});
      end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock)
      if (chk_on) begin
         chk("instr", 32'(Instr_dout), 32'(m_instr));
         chk("npc", 32'(npc_in), 32'(m_npc));
         chk("valid", 32'(out_valid), 32'(m_valid));
         chk("count", 32'(count), 32'(q.size()));
         chk("ready", 32'(push_ready), 32'(reset && q.size() < 4));
         chk("underrun", 32'(underrun_cnt), 32'(m_under));
         chk("npc_auto", 32'(npc_a), 32'(m_npc_a));
         chk("npc_wrap", 32'(npc_w), 32'(m_npc_w));
         chk("instr_auto", 32'(instr_a), 32'(m_instr));
         chk("count_wrap", 32'(count_w), 32'(q.size()));
      end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] n);
      push_valid = 1'b1; push_instr = i; push_npc = n;
      cyc();
      push_valid = 1'b0;
   endtask

   initial begin
      cyc();
      chk_on = 1'b1;
      cyc(); cyc();
      chk("rst_instr", 32'(Instr_dout), 32'h0000);
      chk("rst_npc", 32'(npc_in), 32'h3000);
      chk("rst_npc_wrap", 32'(npc_w), 32'hFFFF);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_ready", 32'(push_ready), 32'h0);
      reset = 1'b1;
      #1 chk("rel_ready", 32'(push_ready), 32'h1);
      push(16'h1234, 16'h3001);
      push(16'h5678, 16'h3002);
      enable_decode = 1'b1;
      cyc();
      chk("ord1_instr", 32'(Instr_dout), 32'h1234);
      chk("ord1_npc", 32'(npc_in), 32'h3001);
      chk("ord1_valid", 32'(out_valid), 32'h1);
      chk("ord1_npc_auto", 32'(npc_a), 32'h3000);
      chk("ord1_npc_wrap", 32'(npc_w), 32'hFFFF);
      cyc();
      chk("ord2_instr", 32'(Instr_dout), 32'h5678);
      chk("ord2_npc", 32'(npc_in), 32'h3002);
      chk("ord2_npc_auto", 32'(npc_a), 32'h3001);
      chk("ord2_npc_wrap", 32'(npc_w), 32'h0000);
      cyc();
      chk("ord3_instr", 32'(Instr_dout), 32'h0000);
      chk("ord3_valid", 32'(out_valid), 32'h0);
      chk("ord3_under", 32'(underrun_cnt), 32'h1);
      enable_decode = 1'b0;
      for (int i = 0; i < 4; i++) push(16'hC001 + 16'(i), 16'h4001 + 16'(i));
      chk("full_count", 32'(count), 32'h4);
      chk("full_ready", 32'(push_ready), 32'h0);
      push(16'hC005, 16'h4005);
      chk("full_drop", 32'(count), 32'h4);
      chk("stall_hold", 32'(Instr_dout), 32'h0000);
      enable_decode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("drain_instr", 32'(Instr_dout), 32'(16'hC001 + 16'(i)));
         chk("drain_npc", 32'(npc_in), 32'(16'h4001 + 16'(i)));
      end
      enable_decode = 1'b0;
      push(16'hD001, 16'h5001);
      push(16'hD002, 16'h5002);
      enable_decode = 1'b1;
      push(16'hD003, 16'h5003);
      chk("pushpop_count", 32'(count), 32'h2);
      chk("pushpop_instr", 32'(Instr_dout), 32'hD001);
      cyc(); cyc();
      chk("pushpop_last", 32'(Instr_dout), 32'hD003);
      enable_decode = 1'b0;
      for (int i = 0; i < 3; i++) push(16'hE001 + 16'(i), 16'h6001 + 16'(i));
      flush = 1'b1; push_valid = 1'b1; push_instr = 16'hE004; enable_decode = 1'b1;
      cyc();
      chk("flush_count", 32'(count), 32'h0);
      chk("flush_instr", 32'(Instr_dout), 32'h0000);
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_npc", 32'(npc_in), 32'h5003);
      flush = 1'b0; push_valid = 1'b0;
      cyc();
      chk("flush_dropped", 32'(out_valid), 32'h0);
      chk("flush_under", 32'(underrun_cnt), 32'h2);
      enable_decode = 1'b0;
      push(16'hF001, 16'h7001);
      enable_decode = 1'b1;
      cyc();
      chk("flush_npc_auto", 32'(npc_a), 32'h3000);
      chk("flush_npc_wrap", 32'(npc_w), 32'hFFFF);
      enable_decode = 1'b0;
      for (int i = 0; i < 3; i++) push(16'hA001 + 16'(i), 16'h8001 + 16'(i));
      chk("mid_count", 32'(count), 32'h3);
      #2 reset = 1'b0;
      #1;
      chk("mid_instr", 32'(Instr_dout), 32'h0000);
      chk("mid_npc", 32'(npc_in), 32'h3000);
      chk("mid_valid", 32'(out_valid), 32'h0);
      chk("mid_count0", 32'(count), 32'h0);
      chk("mid_ready", 32'(push_ready), 32'h0);
      chk("mid_under", 32'(underrun_cnt), 32'h0);
      cyc(); cyc();
      reset = 1'b1;
      cyc(); cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
